fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the MIPS-32 pipeline, directly upstream of the decode stage. Holds the program counter and issues one instruction-memory read at a time. Captures the returned word into the IF/ID pipeline register, which drives decode's `Instruccion` and `Adder_in` inputs. Handles hazard-unit stalls, pipeline flushes, and PC redirects from taken branches and jumps.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `NOP_WORD`, 32'h0000_0000, word injected into IF/ID on flush, redirect, or bubble (`sll $0,$0,0`).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: hold IF/ID contents and PC.
- `flush`  in  1  squash IF/ID to NOP next edge; PC unaffected.
- `branch_taken`  in  1  redirect to `branch_target`.
- `branch_target`  in  32  branch destination from EX.
- `jump`  in  1  redirect to `jump_address`.
- `jump_address`  in  32  from decode's `jump_address_out`.
- `imem_req`  out  1  one-cycle read request.
- `imem_addr`  out  32  word address of the request; equals `pc`.
- `imem_valid`  in  1  read data valid, at least 1 cycle after `imem_req`.
- `imem_rdata`  in  32  instruction word, sampled when `imem_valid` is high.
- `Instruccion`  out  32  IF/ID instruction to decode.
- `Adder_out`  out  32  IF/ID PC+4 to decode's `Adder_in`.
- `valid_out`  out  1  IF/ID holds a real instruction (0 means bubble).

## Operation
- Registers:
  - `pc` (32)
  - `state` (REQ, WAIT, HOLD)
  - `kill` (1)
  - `hold_instr` (32)
  - IF/ID: `Instruccion`, `Adder_out`, `valid_out`
- Redirect:
  - `redirect = branch_taken | jump`.
  - Target is `branch_target` if `branch_taken`, else `jump_address`; branch wins on a tie because it is the older instruction.
- State REQ:
  - `imem_req = !redirect`.
  - If a request is issued, go to WAIT.
  - On redirect, suppress the request, load `pc` with the target, and stay in REQ.
- State WAIT:
  - `imem_valid` and `kill`: discard the data, clear `kill`, go to REQ.
  - `imem_valid`, no kill, no redirect, `!stall`: load IF/ID with {`imem_rdata`, pc+4, 1}, set `pc <= pc+4`, go to REQ.
  - `imem_valid`, no kill, no redirect, `stall`: `hold_instr <= imem_rdata`, go to HOLD.
  - `redirect` without `imem_valid` in the same cycle: set `kill`, load `pc` with the target, stay in WAIT.
  - `redirect` with `imem_valid` in the same cycle: discard the data, load `pc` with the target, go to REQ.
- State HOLD:
  - `!stall`: load IF/ID with {`hold_instr`, pc+4, 1}, set `pc <= pc+4`, go to REQ.
  - `redirect`: drop `hold_instr`, load `pc` with the target, go to REQ.
- IF/ID update rules, in priority order:
  1. `redirect` or `flush`: IF/ID becomes {NOP_WORD, 0, 0}.
  2. Else `stall`: IF/ID holds its value.
  3. Else, with no capture this cycle: IF/ID becomes a bubble {NOP_WORD, 0, 0}.
- Redirect overrides `stall`.
- `flush` without redirect does not change `pc`, `state`, or `kill`.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Targets are used unmodified; the low two bits are not checked.

## Timing
- Reset (asynchronous, immediate):
  - `pc = RESET_PC`, `state = REQ`, `kill = 0`, `hold_instr = 0`.
  - `Instruccion = NOP_WORD`, `Adder_out = 0`, `valid_out = 0`.
  - `imem_req` is high in the first cycle after `rst_n` rises.
- Reset asserted mid-transaction: a late `imem_valid` arriving after reset is ignored, because the block is in REQ, not WAIT.
- `imem_req` and `imem_addr` are combinational from `state`, `pc`, and `redirect`.
- Latency: memory latency L (L ≥ 1) gives IF/ID valid L+1 edges after `imem_req`.
- Throughput: one instruction per L+1 cycles.
- Outstanding requests: at most one. `imem_valid` outside WAIT is ignored.

## Structure
- Package `fetch_pkg`:
  - state enum {REQ, WAIT, HOLD}
  - `RESET_PC` and `NOP_WORD` defaults
  - `PC_INC = 32'd4`
- Sub-module `Buffer_1`: the IF/ID register, with load, hold, and flush controls and asynchronous reset. It is the upstream counterpart of `Buffer_2`.
- FSM, PC, and kill logic live in `fetch_stage`.

## Test plan
- Reset, L=1, memory returns 32'h2008_0005 at address 0: `Instruccion` = 32'h2008_0005, `Adder_out` = 4, `valid_out` = 1 at edge 2. Next `imem_addr` = 4.
- `stall` high for 3 cycles while in WAIT with data returning: HOLD is entered and IF/ID is unchanged. One edge after `stall` drops, IF/ID gets the held word, then the PC advances.
- `jump` to 32'h0040_0010 in WAIT, with `imem_valid` 2 cycles later: returned data is discarded and `valid_out` stays 0. The next request uses address 32'h0040_0010.
- `branch_taken` (target 32'h100) and `jump` (target 32'h200) in the same cycle: next request address = 32'h100. IF/ID = NOP with `valid_out` = 0.
- `flush` alone while IF/ID is valid: IF/ID becomes NOP with `valid_out` = 0; `pc` and the in-flight request are unaffected.
- `pc` = 32'hFFFF_FFFC fetch completes: `Adder_out` = 0 and the next `imem_addr` = 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// No timing of its own; imported by fetch_stage and Buffer_1.
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
   localparam logic [31:0] PC_INC       = 32'd4;

endpackage

// File: rtl/fetch_stage_buffer_1.sv
// IF/ID pipeline register: flush beats hold beats load; an idle cycle leaves a bubble.
// One edge from load to output; hold freezes the contents while decode is stalled.
module Buffer_1
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        hold,
   input  logic        flush,
   input  logic [31:0] next_instr,
   input  logic [31:0] next_adder,
   output logic [31:0] Instruccion,
   output logic [31:0] Adder_out,
   output logic        valid_out
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Instruccion <= NOP_WORD;
         Adder_out   <= 32'd0;
         valid_out   <= 1'b0;
      end else if (flush) begin
         Instruccion <= NOP_WORD;
         Adder_out   <= 32'd0;
         valid_out   <= 1'b0;
      end else if (hold) begin
         Instruccion <= Instruccion;
         Adder_out   <= Adder_out;
         valid_out   <= valid_out;
      end else if (load) begin
         Instruccion <= next_instr;
         Adder_out   <= next_adder;
         valid_out   <= 1'b1;
      end else begin
         Instruccion <= NOP_WORD;
         Adder_out   <= 32'd0;
         valid_out   <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem read FSM, feeds IF/ID. Latency L+1 edges
// per word; stall parks returned data in HOLD, redirects kill any in-flight read.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [31:0] jump_address,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_valid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruccion,
   output logic [31:0] Adder_out,
   output logic        valid_out
);

   state_t      state;
   logic [31:0] pc;
   logic        kill;
   logic [31:0] hold_instr;

   logic        redirect;
   logic [31:0] target;
   logic [31:0] pc_inc;
   logic        capture;
   logic [31:0] cap_instr;

   // Branch is older than the jump in decode, so it wins a tie.
   assign redirect  = branch_taken | jump;
   assign target    = branch_taken ? branch_target : jump_address;
   assign pc_inc    = pc + PC_INC;

   assign imem_req  = (state == REQ) && !redirect;
   assign imem_addr = pc;

   assign capture   = !redirect && !stall &&
                      (((state == WAIT) && imem_valid && !kill) || (state == HOLD));
   assign cap_instr = (state == HOLD) ? hold_instr : imem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= REQ;
         pc         <= RESET_PC;
         kill       <= 1'b0;
         hold_instr <= 32'd0;
      end else begin
         case (state)
            REQ: begin
               if (redirect) pc <= target;
               else          state <= WAIT;
            end
            WAIT: begin
               if (imem_valid) begin
                  if (kill) begin
                     kill  <= 1'b0;
                     state <= REQ;
                     if (redirect) pc <= target;
                  end else if (redirect) begin
                     pc    <= target;
                     state <= REQ;
                  end else if (!stall) begin
                     pc    <= pc_inc;
                     state <= REQ;
                  end else begin
                     hold_instr <= imem_rdata;
                     state      <= HOLD;
                  end
               end else if (redirect) begin
                  // Read still in flight: remember to drop its data when it lands.
                  kill <= 1'b1;
                  pc   <= target;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc    <= target;
                  state <= REQ;
               end else if (!stall) begin
                  pc    <= pc_inc;
                  state <= REQ;
               end
            end
            default: state <= REQ;
         endcase
      end
   end

   Buffer_1 #(
      .NOP_WORD(NOP_WORD)
   ) u_if_id (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (capture),
      .hold       (stall),
      .flush      (redirect | flush),
      .next_instr (cap_instr),
      .next_adder (pc_inc),
      .Instruccion(Instruccion),
      .Adder_out  (Adder_out),
      .valid_out  (valid_out)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage; one row per clock cycle.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall, flush, branch_taken, jump, imem_valid;
   logic [31:0] branch_target, jump_address, imem_rdata;
   logic        imem_req, valid_out;
   logic [31:0] imem_addr, Instruccion, Adder_out;

   fetch_stage #(
      .RESET_PC(32'h0000_0000),
      .NOP_WORD(32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .flush        (flush),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .jump         (jump),
      .jump_address (jump_address),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_valid   (imem_valid),
      .imem_rdata   (imem_rdata),
      .Instruccion  (Instruccion),
      .Adder_out    (Adder_out),
      .valid_out    (valid_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic        fl;
      logic        br;
      logic [31:0] bt;
      logic        jp;
      logic [31:0] ja;
      logic        iv;
      logic [31:0] id;
      logic        req;
      logic [31:0] addr;
      logic [31:0] ins;
      logic [31:0] add;
      logic        vld;
   } vec_t;

   localparam logic [31:0] I0 = 32'h2008_0005;
   localparam logic [31:0] IA = 32'h8C01_0004;
   localparam logic [31:0] IB = 32'h3C08_1234;
   localparam logic [31:0] IC = 32'h2129_0001;
   localparam logic [31:0] ID = 32'hAC0A_0008;
   localparam logic [31:0] IE = 32'h1234_5678;
   localparam logic [31:0] IF = 32'h0800_0000;
   localparam logic [31:0] IG = 32'hBAD0_0001;
   localparam logic [31:0] IH = 32'h0109_4020;
   localparam logic [31:0] JK = 32'hDEAD_BEEF;
   localparam logic [31:0] Z  = 32'h0000_0000;

   vec_t tbl [28];
   vec_t hv;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string tag);
      stall         = v.st;
      flush         = v.fl;
      branch_taken  = v.br;
      branch_target = v.bt;
      jump          = v.jp;
      jump_address  = v.ja;
      imem_valid    = v.iv;
      imem_rdata    = v.id;
      #1;
      check({tag, " imem_req"},  {31'd0, imem_req}, {31'd0, v.req});
      check({tag, " imem_addr"}, imem_addr, v.addr);
      @(posedge clk);
      #1;
      check({tag, " Instruccion"}, Instruccion, v.ins);
      check({tag, " Adder_out"},   Adder_out, v.add);
      check({tag, " valid_out"},   {31'd0, valid_out}, {31'd0, v.vld});
   endtask

   initial begin
      //           st    fl    br    bt             jp    ja             iv    id    req   addr           ins add            vld
      tbl[0]  = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b1, Z,             Z,  Z,             1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b1, I0, 1'b0, Z,             I0, 32'd4,         1'b1};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b1, 32'd4,         I0, 32'd4,         1'b1};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             1'b1, IA, 1'b0, 32'd4,         I0, 32'd4,         1'b1};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b0, 32'd4,         I0, 32'd4,         1'b1};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b0, 32'd4,         IA, 32'd8,         1'b1};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b1, 32'd8,         Z,  Z,             1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, Z,             1'b1, 32'h0040_0010, 1'b0, Z,  1'b0, 32'd8,         Z,  Z,             1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b0, 32'h0040_0010, Z,  Z,             1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b1, JK, 1'b0, 32'h0040_0010, Z,  Z,             1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b1, 32'h0040_0010, Z,  Z,             1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b1, IB, 1'b0, 32'h0040_0010, IB, 32'h0040_0014, 1'b1};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h100,       1'b1, 32'h200,       1'b0, Z,  1'b0, 32'h0040_0014, Z,  Z,             1'b0};
      tbl[13] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b1, 32'h100,       Z,  Z,             1'b0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b1, IC, 1'b0, 32'h100,       IC, 32'h104,       1'b1};
      tbl[15] = '{1'b1, 1'b1, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b1, 32'h104,       Z,  Z,             1'b0};
      tbl[16] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b1, ID, 1'b0, 32'h104,       ID, 32'h108,       1'b1};
      tbl[17] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b1, 32'h108,       Z,  Z,             1'b0};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, Z,             1'b1, IE, 1'b0, 32'h108,       Z,  Z,             1'b0};
      tbl[19] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b1, 32'hFFFF_FFFC, Z,  Z,             1'b0};
      tbl[20] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b1, IF, 1'b0, 32'hFFFF_FFFC, IF, Z,             1'b1};
      tbl[21] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b1, Z,             Z,  Z,             1'b0};
      tbl[22] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b1, I0, 1'b0, Z,             I0, 32'd4,         1'b1};
      tbl[23] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b0, Z,  1'b1, 32'd4,         Z,  Z,             1'b0};
      tbl[24] = '{1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             1'b1, IG, 1'b0, 32'd4,         Z,  Z,             1'b0};
      tbl[25] = '{1'b1, 1'b0, 1'b0, Z,             1'b1, 32'h40,        1'b0, Z,  1'b0, 32'd4,         Z,  Z,             1'b0};
      tbl[26] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b1, JK, 1'b1, 32'h40,        Z,  Z,             1'b0};
      tbl[27] = '{1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             1'b1, IH, 1'b0, 32'h40,        IH, 32'h44,        1'b1};

      rst_n = 1'b0;
      stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0; imem_valid = 1'b0;
      branch_target = Z; jump_address = Z; imem_rdata = Z;
      #2;
      check("reset Instruccion", Instruccion, Z);
      check("reset Adder_out",   Adder_out, Z);
      check("reset valid_out",   {31'd0, valid_out}, 32'd0);
      check("reset imem_addr",   imem_addr, Z);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 28; i++) apply(tbl[i], $sformatf("row%0d", i));

      // Stall keeps the valid word while a new read is issued, then reset lands mid-read.
      hv = '{1'b1, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, Z, 1'b1, 32'h44, IH, 32'h44, 1'b1};
      apply(hv, "pre_reset");
      #2 rst_n = 1'b0;
      #1;
      check("midreset Instruccion", Instruccion, Z);
      check("midreset Adder_out",   Adder_out, Z);
      check("midreset valid_out",   {31'd0, valid_out}, 32'd0);
      check("midreset imem_addr",   imem_addr, Z);
      check("midreset imem_req",    {31'd0, imem_req}, 32'd1);
      #1 rst_n = 1'b1;

      // Late data after reset is ignored; then a 2-cycle memory latency fetch.
      hv = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b1, JK, 1'b1, Z, Z, Z, 1'b0};
      apply(hv, "late_data");
      hv = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, Z, 1'b0, Z, Z, Z, 1'b0};
      apply(hv, "l2_wait");
      hv = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b1, I0, 1'b0, Z, I0, 32'd4, 1'b1};
      apply(hv, "l2_data");
      hv = '{1'b0, 1'b0, 1'b0, Z, 1'b0, Z, 1'b0, Z, 1'b1, 32'd4, Z, Z, 1'b0};
      apply(hv, "l2_next");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
